mul_seq_collect: RTL

Downstream consumer of the four-cycle constant-multiplier sequencer (×1, ×3, ×7, ×8 of a latched 8-bit operand). It captures each four-product frame, checks every product against its expected multiple of the base operand, and accumulates the frame sum, which equals base×19. Each completed frame is queued as a record {base, sum, err} in a small output FIFO with a valid/ready handshake for the next stage.

---
 rtl/mul_seq_collect_pkg.sv | 28 ++
 rtl/mul_rec_fifo.sv | 68 ++++++
 rtl/mul_seq_collect.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mul_seq_collect_pkg.sv
// Shared constants and types for the constant-multiplier frame collector.
// The collector consumes frames of x1, x3, x7, x8 products of one base operand.
package mul_seq_collect_pkg;

  localparam int unsigned MUL0 = 1;
  localparam int unsigned MUL1 = 3;
  localparam int unsigned MUL2 = 7;
  localparam int unsigned MUL3 = 8;

  localparam int unsigned BASE_W = 8;
  localparam int unsigned IN_W   = 11;
  localparam int unsigned SUM_W  = 13;

  // State names the next product expected in the frame.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StP1   = 2'd1,
    StP2   = 2'd2,
    StP3   = 2'd3
  } coll_state_e;

  typedef struct packed {
    logic [BASE_W-1:0] base;
    logic [SUM_W-1:0]  sum;
    logic              err;
  } rec_t;

endpackage

// File: rtl/mul_rec_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle.
module mul_rec_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      // When full, wr_ptr equals rd_ptr: overwriting the popped head is intended.
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/mul_seq_collect.sv
// Collects x1/x3/x7/x8 product frames, checks each product against the latched
// base and queues {base, sum, err} records behind a valid/ready handshake.
module mul_seq_collect #(
  parameter int unsigned IN_W  = mul_seq_collect_pkg::IN_W,
  parameter int unsigned SUM_W = mul_seq_collect_pkg::SUM_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_grant,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_base,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_err,
  output logic             frm_abort,
  output logic             ovf
);

  import mul_seq_collect_pkg::*;

  localparam int unsigned REC_W = BASE_W + SUM_W + 1;

  coll_state_e       state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;
  logic              ovf_q, ovf_d;

  logic [IN_W-1:0]   base_ext, exp3, exp7, exp8;
  logic [SUM_W-1:0]  in_ext, acc_sum;
  logic              hi_nz, start;
  logic              push, pop;
  logic [REC_W-1:0]  push_rec, head;
  logic              fifo_full, fifo_empty;

  // Expected products built from shifts and adds only.
  assign base_ext = IN_W'(base_q);
  assign exp3     = (base_ext << 1) + base_ext;
  assign exp7     = (base_ext << 3) - base_ext;
  assign exp8     = base_ext << 3;

  assign in_ext   = SUM_W'(in);
  assign acc_sum  = acc_q + in_ext;
  assign hi_nz    = |in[IN_W-1:BASE_W];
  // A grant in P3 is swallowed by the frame completion.
  assign start    = input_grant && (state_q != StP3);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    acc_d    = acc_q;
    err_d    = err_q;
    abort_d  = 1'b0;
    push     = 1'b0;
    push_rec = '0;
    if (start) begin
      base_d  = in[BASE_W-1:0];
      acc_d   = in_ext;
      err_d   = hi_nz;
      state_d = StP1;
      abort_d = (state_q != StIdle);
    end else begin
      case (state_q)
        StP1: begin
          acc_d   = acc_sum;
          err_d   = err_q | (in != exp3);
          state_d = StP2;
        end
        StP2: begin
          acc_d   = acc_sum;
          err_d   = err_q | (in != exp7);
          state_d = StP3;
        end
        StP3: begin
          push     = 1'b1;
          push_rec = {base_q, acc_sum, err_q | (in != exp8)};
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign ovf_d     = push && fifo_full && !pop;

  mul_rec_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign out_base  = fifo_empty ? '0 : head[REC_W-1 -: BASE_W];
  assign out_sum   = fifo_empty ? '0 : head[SUM_W:1];
  assign out_err   = fifo_empty ? 1'b0 : head[0];
  assign frm_abort = abort_q;
  assign ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
